// File: rtl/clk_div_gen.sv
// Integer clock divider for the UART sampling clock: even/odd ratios, ratio 0/1 and
// Clk_En bypass, ratio updates only at period boundaries, plus a rising-edge tick.
//
// state  | meaning
// S_LOW  | divided clock low, counting low_len = N>>1 cycles
// S_HIGH | divided clock high, counting high_len = N - (N>>1) cycles
// (bypass overrides both: Div_Clk = CLK, state parked in S_LOW with cnt = 0)
module clk_div_gen #(
  parameter int RATIO_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Clk_En,
  input  logic [RATIO_WIDTH-1:0] Div_Ratio,
  output logic                   Div_Clk,
  output logic                   Div_Tick
);

  localparam int CW = RATIO_WIDTH - 1;

  typedef enum logic {S_LOW = 1'b0, S_HIGH = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [RATIO_WIDTH-1:0] act_ratio, ratio_nxt;
  logic                   tick_reg, tick_nxt;

  logic [RATIO_WIDTH-1:0] low_len;
  logic [RATIO_WIDTH-1:0] high_len;
  logic                   bypass;
  logic                   low_done;
  logic                   high_done;

  assign low_len   = act_ratio >> 1;
  assign high_len  = act_ratio - low_len;
  assign bypass    = !Clk_En || (act_ratio < RATIO_WIDTH'(2));
  assign low_done  = ({1'b0, cnt} == (low_len - RATIO_WIDTH'(1)));
  assign high_done = ({1'b0, cnt} == (high_len - RATIO_WIDTH'(1)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_LOW;
      cnt       <= '0;
      act_ratio <= Div_Ratio;
      tick_reg  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      act_ratio <= ratio_nxt;
      tick_reg  <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ratio_nxt = act_ratio;
    tick_nxt  = 1'b0;
    if (bypass) begin
      // keep sampling the requested ratio so enable-rise starts with a fresh one
      state_nxt = S_LOW;
      cnt_nxt   = '0;
      ratio_nxt = Div_Ratio;
      tick_nxt  = Clk_En;
    end else begin
      case (state)
        S_LOW: begin
          if (low_done) begin
            state_nxt = S_HIGH;
            cnt_nxt   = '0;
            tick_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_HIGH: begin
          if (high_done) begin
            state_nxt = S_LOW;
            cnt_nxt   = '0;
            ratio_nxt = Div_Ratio;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // CLK passes straight through only in bypass; otherwise a registered level
  always_comb begin
    Div_Clk  = bypass ? CLK : (state == S_HIGH);
    Div_Tick = tick_reg;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed scenarios with literal expectations plus randomized
// stimulus checked every cycle against a position-in-period model.
module tb_clk_div_gen;

  logic       clk_ref;
  logic       rst;
  logic       clk_en;
  logic [7:0] div_ratio;
  logic       div_clk;
  logic       div_tick;

  int n_checks = 0;
  int n_pass   = 0;

  clk_div_gen #(.RATIO_WIDTH(8)) dut (
    .CLK       (clk_ref),
    .RST       (rst),
    .Clk_En    (clk_en),
    .Div_Ratio (div_ratio),
    .Div_Clk   (div_clk),
    .Div_Tick  (div_tick)
  );

  initial clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: position within the current period; high once pos reaches floor(N/2).
  int         m_pos;
  logic [7:0] m_ratio;
  logic       m_tick;
  logic       m_valid = 1'b0;

  initial begin
    logic r, e;
    logic [7:0] d;
    logic exp_clk;
    forever begin
      @(posedge clk_ref);
      r = rst; e = clk_en; d = div_ratio;
      if (r) begin
        m_ratio = d; m_pos = 0; m_tick = 1'b0; m_valid = 1'b1;
      end else if (m_valid) begin
        if (!e || m_ratio < 2) begin
          m_ratio = d; m_pos = 0; m_tick = e;
        end else begin
          m_pos++;
          m_tick = 1'b0;
          if (m_pos == int'(m_ratio)) begin
            m_pos = 0; m_ratio = d;
          end else if (m_pos == int'(m_ratio / 2)) begin
            m_tick = 1'b1;
          end
        end
      end
      #1;
      if (m_valid) begin
        // sampled while CLK is high, so bypass must read 1
        exp_clk = (!clk_en || m_ratio < 2) ? 1'b1 : (m_pos >= int'(m_ratio / 2));
        check("model_clk", div_clk, exp_clk);
        check("model_tick", div_tick, m_tick);
      end
    end
  end

  task automatic do_reset(input logic [7:0] ratio, input logic en);
    @(negedge clk_ref);
    rst = 1'b1; div_ratio = ratio; clk_en = en;
  endtask

  task automatic collect(input string name, input int n, input logic [15:0] ec, input logic [15:0] et);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_ref); #1;
      check({name, "_clk"}, div_clk, ec[i]);
      check({name, "_tick"}, div_tick, et[i]);
      @(negedge clk_ref);
      rst = 1'b0;
    end
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_ref);
      @(negedge clk_ref);
      rst = 1'b0;
    end
  endtask

  function automatic logic [7:0] pick_ratio();
    int sel = $urandom_range(0, 3);
    if (sel == 0) return 8'($urandom_range(0, 3));
    else if (sel == 3) return 8'($urandom_range(0, 255));
    else return 8'($urandom_range(2, 20));
  endfunction

  initial begin
    int lows, highs, ticks, pre_high;
    logic seen_high;
    rst = 1'b1; clk_en = 1'b1; div_ratio = 8'd4;

    // sample 0 is the reset edge; literals list samples LSB first
    do_reset(8'd4, 1'b1); collect("r4", 8,  16'b11001100,   16'b01000100);
    do_reset(8'd5, 1'b1); collect("r5", 10, 16'b1110011100, 16'b0010000100);
    do_reset(8'd3, 1'b1); collect("r3", 6,  16'b110110,     16'b010010);
    do_reset(8'd1, 1'b1); collect("r1", 4,  16'b1111,       16'b1110);
    do_reset(8'd0, 1'b1); collect("r0", 4,  16'b1111,       16'b1110);
    do_reset(8'd6, 1'b0); collect("en0", 4, 16'b1111,       16'b0000);

    // N=8, ratio switched to 2 during the third high cycle
    do_reset(8'd8, 1'b1); skip(7);
    div_ratio = 8'd2;
    collect("r8to2", 5, 16'b10101, 16'b10100);

    // N=6, enable dropped after low cycle 1 for 5 cycles
    do_reset(8'd6, 1'b1); skip(2);
    clk_en = 1'b0;
    collect("en_off", 5, 16'b11111, 16'b00000);
    clk_en = 1'b1;
    collect("en_on", 6, 16'b011100, 16'b000100);

    // N=255: 127 low, 128 high, one tick per period
    do_reset(8'd255, 1'b1);
    lows = 0; highs = 0; ticks = 0;
    for (int i = 0; i < 255; i++) begin
      @(posedge clk_ref); #1;
      if (div_clk) highs++; else lows++;
      if (div_tick) ticks++;
      @(negedge clk_ref); rst = 1'b0;
    end
    check_int("r255_low", lows, 127);
    check_int("r255_high", highs, 128);
    check_int("r255_ticks", ticks, 1);
    skip(199);
    @(posedge clk_ref); #1;
    check("r255_midhigh", div_clk, 1'b1);
    @(negedge clk_ref);
    rst = 1'b1;
    collect("r255_rst", 1, 16'b0, 16'b0);
    pre_high = 0; seen_high = 1'b0;
    for (int i = 0; i < 140; i++) begin
      @(posedge clk_ref); #1;
      if (div_clk) seen_high = 1'b1;
      else if (!seen_high) pre_high++;
      @(negedge clk_ref);
    end
    check_int("r255_relow", pre_high + 1, 127);

    // randomized stimulus, checked by the model process
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk_ref);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 63) == 0) div_ratio = pick_ratio();
      if ($urandom_range(0, 99) == 0) clk_en = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk_ref);
    rst = 1'b0;
    repeat (3) @(posedge clk_ref);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Integer clock divider that consumes the 8-bit division ratio produced by the prescale-to-ratio mapping. It generates the UART RX/TX sampling clock from the reference clock.
- Supports even and odd ratios, ratio 0/1 bypass, and a clock-enable gate.
- Ratio changes take effect only at period boundaries, so no runt pulses reach downstream UART logic.
- Also emits a one-CLK-wide tick aligned to each divided-clock rising edge, used by synchronous consumers and the bench.

Parameters:
RATIO_WIDTH, 8, width of Div_Ratio and of the internal latched ratio.

Ports:
CLK  input  1  reference clock
RST  input  1  synchronous reset, active-high
Clk_En  input  1  divider enable; 0 forces bypass
Div_Ratio  input  RATIO_WIDTH  requested division ratio, N
Div_Clk  output  1  divided clock (CLK itself in bypass)
Div_Tick  output  1  registered pulse, high for the first CLK cycle of each Div_Clk high phase

Behaviour:
- Internal registers:
  - act_ratio [RATIO_WIDTH-1:0]: latched ratio
  - cnt [RATIO_WIDTH-2:0]: phase counter
  - div_reg: divided clock state
  - tick_reg: tick state
- Phase lengths from act_ratio (N):
  - low_len = N>>1
  - high_len = N - (N>>1), i.e. ceil(N/2); odd N has the longer high phase
- bypass = (Clk_En==0) || (act_ratio < 2).
- Reset (RST=1 at a CLK edge):
  - act_ratio <= Div_Ratio
  - cnt <= 0, div_reg <= 0, tick_reg <= 0
  - Outputs immediately after reset: Div_Clk=0 (or CLK if the loaded ratio <2), Div_Tick=0.
- Bypass cycle (bypass=1):
  - cnt <= 0, div_reg <= 0
  - act_ratio <= Div_Ratio, reloaded every cycle
  - tick_reg <= Clk_En
  - Div_Clk = CLK, as a combinational mux.
- Divide mode, low phase (div_reg=0):
  - If cnt == low_len-1: div_reg <= 1, cnt <= 0, tick_reg <= 1.
  - Else: cnt <= cnt+1, tick_reg <= 0.
- Divide mode, high phase (div_reg=1):
  - tick_reg <= 0.
  - If cnt == high_len-1: div_reg <= 0, cnt <= 0, act_ratio <= Div_Ratio (period boundary).
  - Else: cnt <= cnt+1.
- Div_Clk = bypass ? CLK : div_reg. Div_Tick = tick_reg.
- Period is exactly N CLK cycles: low_len low, then high_len high.
- Div_Ratio changes mid-period are ignored until the high->low boundary. A change to 0/1 enters bypass at that boundary.
- Clk_En falling mid-period: bypass on the next edge; the counter and phase restart from the low phase once Clk_En returns.
- Clk_En rising: the first divide period starts with the full low phase, using the act_ratio loaded during bypass.
- RST takes priority over Clk_En and all counting; reset mid-period aborts the period with no extra edges afterwards.
- Ratio 255 (max): low 127, high 128; cnt must hold 127 without overflow.
- Bypass output glitch is accepted because CLK passes straight through. No other combinational path may drive Div_Clk.

Test Plan:
- RST pulse, Div_Ratio=4, Clk_En=1 -> Div_Clk low 2, high 2, period 4; Div_Tick pulses every 4 CLK, first at cycle 3 after reset release.
- Div_Ratio=5 -> low 2, high 3, period 5; Div_Ratio=3 -> low 1, high 2; every Div_Tick coincides with a Div_Clk rising edge.
- Div_Ratio=1 then 0, Clk_En=1 -> Div_Clk follows CLK; Div_Tick constantly 1. Clk_En=0 -> Div_Clk follows CLK; Div_Tick 0.
- Running at N=8, switch Div_Ratio to 2 at cycle 3 of the high phase -> the current period completes 4 low + 4 high, then period 2. No pulse shorter than 1 CLK.
- Clk_En dropped at low-phase cycle 1 of N=6, restored 5 cycles later -> bypass while low; on return, a full 3-low/3-high period.
- Div_Ratio=255 for 600 cycles -> period 255 (127 low, 128 high); assert RST mid-high phase -> Div_Clk=0 next edge, restart with a full low phase.
